// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Constants and types shared by the elevator controller and
//                the floor request scheduler (sweep directions, scheduler
//                state encoding, default floor index width).
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    // Sweep direction encoding
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Default floor index width, matches the controller floor ports
    localparam int DEFAULT_FLOOR_W = 4;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_TRAVEL = 2'd2,
        ST_DWELL  = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/floor_request_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : floor_request_scheduler_if
//  Description : Call buttons, controller feedback and scheduler outputs
//                bundled for the floor request scheduler. The scheduler
//                uses the slave view; the car/controller side uses master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface floor_request_scheduler_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = DEFAULT_FLOOR_W
);
    logic [NUM_FLOORS-1:0] CALL_REQ;
    logic [FLOOR_W-1:0]    CURRENT_FLOOR;
    logic                  COMPLETE;
    logic                  DOOR_ALERT;
    logic                  WEIGHT_ALERT;
    logic [FLOOR_W-1:0]    REQUESTED_FLOOR;
    logic                  TARGET_VALID;
    logic                  SCAN_DIR;
    logic                  DOOR_OPEN;
    logic [NUM_FLOORS-1:0] PENDING;

    modport master (
        output CALL_REQ, CURRENT_FLOOR, COMPLETE, DOOR_ALERT, WEIGHT_ALERT,
        input  REQUESTED_FLOOR, TARGET_VALID, SCAN_DIR, DOOR_OPEN, PENDING
    );

    modport slave (
        input  CALL_REQ, CURRENT_FLOOR, COMPLETE, DOOR_ALERT, WEIGHT_ALERT,
        output REQUESTED_FLOOR, TARGET_VALID, SCAN_DIR, DOOR_OPEN, PENDING
    );

endinterface
`default_nettype wire

// File: rtl/floor_request_scheduler_floor_pick.sv
`default_nettype none
// ============================================================================
//  Module      : floor_request_scheduler_floor_pick
//  Description : Combinational SCAN search over the pending-call set.
//                Returns the next target (current floor first, then nearest
//                ahead in the sweep direction, then nearest the other way
//                with a direction flip) and, separately, the nearest pending
//                floor ahead for en-route pickup decisions.
//  Revision    : 1.0 - initial release
// ============================================================================
module floor_request_scheduler_floor_pick
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = DEFAULT_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    cur_i,
    input  logic                  dir_i,
    output logic                  found_o,
    output logic [FLOOR_W-1:0]    floor_o,
    output logic                  dir_o,
    output logic                  ahead_found_o,
    output logic [FLOOR_W-1:0]    ahead_floor_o
);

    logic               w_at_cur;
    logic               w_up_found;
    logic [FLOOR_W-1:0] w_up_floor;
    logic               w_dn_found;
    logic [FLOOR_W-1:0] w_dn_floor;
    logic               w_behind_found;
    logic [FLOOR_W-1:0] w_behind_floor;

    // Bounded searches: a current floor beyond the top served floor matches
    // nothing, finds nothing above and sees every floor as below.
    always_comb begin
        w_at_cur   = 1'b0;
        w_up_found = 1'b0;
        w_up_floor = '0;
        w_dn_found = 1'b0;
        w_dn_floor = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_i[i] && (FLOOR_W'(i) == cur_i)) begin
                w_at_cur = 1'b1;
            end
        end
        // scanning downward leaves the lowest floor above current
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_i[i] && (FLOOR_W'(i) > cur_i)) begin
                w_up_found = 1'b1;
                w_up_floor = FLOOR_W'(i);
            end
        end
        // scanning upward leaves the highest floor below current
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_i[i] && (FLOOR_W'(i) < cur_i)) begin
                w_dn_found = 1'b1;
                w_dn_floor = FLOOR_W'(i);
            end
        end
    end

    // Priority pick: at current floor, ahead in sweep, then reversed sweep
    always_comb begin
        ahead_found_o  = (dir_i == DIR_UP) ? w_up_found : w_dn_found;
        ahead_floor_o  = (dir_i == DIR_UP) ? w_up_floor : w_dn_floor;
        w_behind_found = (dir_i == DIR_UP) ? w_dn_found : w_up_found;
        w_behind_floor = (dir_i == DIR_UP) ? w_dn_floor : w_up_floor;
        found_o        = 1'b0;
        floor_o        = cur_i;
        dir_o          = dir_i;
        if (w_at_cur) begin
            found_o = 1'b1;
        end else if (ahead_found_o) begin
            found_o = 1'b1;
            floor_o = ahead_floor_o;
        end else if (w_behind_found) begin
            found_o = 1'b1;
            floor_o = w_behind_floor;
            dir_o   = ~dir_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/floor_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : floor_request_scheduler
//  Description : Latches hall/cab calls into a pending set and dispatches
//                target floors to the elevator controller with a SCAN
//                policy, including en-route pickups, and times the door
//                dwell at every stop (extended by door/weight alerts).
//  Revision    : 1.0 - initial release
// ============================================================================
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 16,
    parameter int FLOOR_W      = DEFAULT_FLOOR_W,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    floor_request_scheduler_if.slave sched_io
);

    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL_CYCLES - 1);

    sched_state_t          state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    req_q, req_d;
    logic                  tv_q, tv_d;
    logic                  dir_q, dir_d;
    logic                  door_q, door_d;
    logic                  first_q, first_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;

    logic                  w_pick_found;
    logic [FLOOR_W-1:0]    w_pick_floor;
    logic                  w_pick_dir;
    logic                  w_ahead_found;
    logic [FLOOR_W-1:0]    w_ahead_floor;
    logic [NUM_FLOORS-1:0] w_absorb;
    logic [NUM_FLOORS-1:0] w_clear;
    logic                  w_arrival;
    logic                  w_cur_call;
    logic                  w_alert;
    logic                  w_pickup;

    floor_request_scheduler_floor_pick #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_pick (
        .pending_i     (pending_q),
        .cur_i         (sched_io.CURRENT_FLOOR),
        .dir_i         (dir_q),
        .found_o       (w_pick_found),
        .floor_o       (w_pick_floor),
        .dir_o         (w_pick_dir),
        .ahead_found_o (w_ahead_found),
        .ahead_floor_o (w_ahead_floor)
    );

    // Arrival, pickup and call-masking terms; COMPLETE lags the target by
    // one cycle, so the first TRAVEL cycle never counts as an arrival.
    always_comb begin
        w_absorb = '0;
        w_clear  = '0;
        w_arrival = (state_q == ST_TRAVEL) && !first_q && sched_io.COMPLETE &&
                    (sched_io.CURRENT_FLOOR == req_q);
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_absorb[i] = (state_q == ST_DWELL) &&
                          (FLOOR_W'(i) == sched_io.CURRENT_FLOOR);
            w_clear[i]  = w_arrival && (FLOOR_W'(i) == req_q);
        end
        w_cur_call = |(sched_io.CALL_REQ & w_absorb);
        w_alert    = sched_io.DOOR_ALERT | sched_io.WEIGHT_ALERT;
        w_pickup   = w_ahead_found &&
                     ((dir_q == DIR_UP) ? (w_ahead_floor < req_q)
                                        : (w_ahead_floor > req_q));
        pending_d  = (pending_q | (sched_io.CALL_REQ & ~w_absorb)) & ~w_clear;
    end

    // Next-state and registered-output logic for the dispatch FSM
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        tv_d    = tv_q;
        dir_d   = dir_q;
        door_d  = door_q;
        dwell_d = dwell_q;
        first_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_d = sched_io.CURRENT_FLOOR;
                if (pending_q != '0) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (w_pick_found) begin
                    req_d   = w_pick_floor;
                    dir_d   = w_pick_dir;
                    tv_d    = 1'b1;
                    first_d = 1'b1;
                    state_d = ST_TRAVEL;
                end else begin
                    req_d   = sched_io.CURRENT_FLOOR;
                    state_d = ST_IDLE;
                end
            end
            ST_TRAVEL: begin
                if (w_arrival) begin
                    tv_d    = 1'b0;
                    door_d  = 1'b1;
                    dwell_d = DWELL_RELOAD;
                    state_d = ST_DWELL;
                end else if (w_pickup) begin
                    req_d = w_ahead_floor;
                end
            end
            ST_DWELL: begin
                if (w_alert || w_cur_call) begin
                    dwell_d = DWELL_RELOAD;
                end else if (dwell_q == '0) begin
                    door_d  = 1'b0;
                    state_d = ST_SELECT;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset holds the car where it stands
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            req_q     <= sched_io.CURRENT_FLOOR;
            tv_q      <= 1'b0;
            dir_q     <= DIR_UP;
            door_q    <= 1'b0;
            first_q   <= 1'b0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            tv_q      <= tv_d;
            dir_q     <= dir_d;
            door_q    <= door_d;
            first_q   <= first_d;
            dwell_q   <= dwell_d;
        end
    end

    assign sched_io.REQUESTED_FLOOR = req_q;
    assign sched_io.TARGET_VALID    = tv_q;
    assign sched_io.SCAN_DIR        = dir_q;
    assign sched_io.DOOR_OPEN       = door_q;
    assign sched_io.PENDING         = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_floor_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floor_request_scheduler
//  Description : Scoreboard bench for the floor request scheduler with a
//                simple car model (one floor per MOVE_CYC cycles, COMPLETE
//                one cycle stale) and a SCAN service-order model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_floor_request_scheduler;
    import elevator_pkg::*;

    localparam int NF       = 16;
    localparam int FW       = 4;
    localparam int DW       = 8;
    localparam int MOVE_CYC = 4;
    localparam int LIMIT    = 4000;

    typedef struct {
        int floor;
        bit dir;
    } stop_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stop_t exp_stop[$];
    int    exp_dwell[$];
    int    errors = 0;
    int    checks = 0;
    bit    m_dir  = 1'b1;

    floor_request_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    floor_request_scheduler #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Car model: steps toward the target, reports arrival one cycle late
    initial begin : car_model
        int  timer;
        bit  last_match;
        bus.CURRENT_FLOOR = FW'(3);
        bus.COMPLETE      = 1'b0;
        timer      = 0;
        last_match = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.COMPLETE = last_match;
            if (bus.CURRENT_FLOOR != bus.REQUESTED_FLOOR) begin
                if (timer == MOVE_CYC - 1) begin
                    timer = 0;
                    if (bus.REQUESTED_FLOOR > bus.CURRENT_FLOOR)
                        bus.CURRENT_FLOOR = bus.CURRENT_FLOOR + 1'b1;
                    else
                        bus.CURRENT_FLOOR = bus.CURRENT_FLOOR - 1'b1;
                end else begin
                    timer++;
                end
            end else begin
                timer = 0;
            end
            last_match = (bus.CURRENT_FLOOR == bus.REQUESTED_FLOOR);
        end
    end

    // Monitor: every door opening is a stop, every closing ends a dwell
    initial begin : monitor
        bit    prev_door;
        int    run;
        stop_t s;
        prev_door = 1'b0;
        run       = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_door = 1'b0;
                run       = 0;
            end else begin
                if (bus.DOOR_OPEN && !prev_door) begin
                    if (exp_stop.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_stop: got floor %0d expected none", bus.CURRENT_FLOOR);
                    end else begin
                        s = exp_stop.pop_front();
                        check("stop_floor", int'(bus.CURRENT_FLOOR), s.floor);
                        check("stop_dir", int'(bus.SCAN_DIR), int'(s.dir));
                        check("served_cleared", int'(bus.PENDING[s.floor]), 0);
                    end
                    run = 1;
                end else if (bus.DOOR_OPEN) begin
                    run++;
                end else if (prev_door) begin
                    if (exp_dwell.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dwell: got %0d cycles expected none", run);
                    end else begin
                        check("dwell_len", run, exp_dwell.pop_front());
                    end
                end
                prev_door = bus.DOOR_OPEN;
            end
        end
    end

    task automatic push_stop(input int f, input bit d);
        stop_t s;
        s.floor = f;
        s.dir   = d;
        exp_stop.push_back(s);
        exp_dwell.push_back(DW);
    endtask

    // Serve every remaining call reachable from cur in direction d, nearest first
    task automatic sweep(input int cur, input bit d, inout logic [NF-1:0] m);
        if (d) begin
            for (int f = cur + 1; f < NF; f++)
                if (m[f]) begin push_stop(f, d); m[f] = 1'b0; end
        end else begin
            for (int f = cur - 1; f >= 0; f--)
                if (m[f]) begin push_stop(f, d); m[f] = 1'b0; end
        end
    endtask

    // SCAN order for a batch of calls latched while the car rests at cur
    task automatic plan_batch(input logic [NF-1:0] mask, input int cur);
        logic [NF-1:0] m;
        bit            d;
        m = mask;
        d = m_dir;
        if (m[cur]) begin
            push_stop(cur, d);
            m[cur] = 1'b0;
        end
        sweep(cur, d, m);
        if (m != '0) begin
            d = ~d;
            sweep(cur, d, m);
        end
        m_dir = d;
    endtask

    task automatic pulse_calls(input logic [NF-1:0] mask);
        @(negedge clk);
        bus.CALL_REQ = mask;
        @(negedge clk);
        bus.CALL_REQ = '0;
    endtask

    task automatic issue_batch(input logic [NF-1:0] mask);
        plan_batch(mask, int'(bus.CURRENT_FLOOR));
        pulse_calls(mask);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_stop.size() != 0 || exp_dwell.size() != 0 ||
                bus.DOOR_OPEN || bus.TARGET_VALID) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL %s_timeout: got %0d stops outstanding expected 0", name, exp_stop.size());
            exp_stop.delete();
            exp_dwell.delete();
        end
        repeat (3) @(negedge clk);
        check({name, "_pending_empty"}, int'(bus.PENDING), 0);
    endtask

    task automatic wait_door(input string name);
        int n;
        n = 0;
        while (!bus.DOOR_OPEN && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({name, "_door_opened"}, int'(bus.DOOR_OPEN), 1);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin : stim
        logic [NF-1:0] mask;
        int            n;
        bus.CALL_REQ     = '0;
        bus.DOOR_ALERT   = 1'b0;
        bus.WEIGHT_ALERT = 1'b0;

        // reset while parked at floor 3
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", int'(bus.REQUESTED_FLOOR), 3);
        check("rst_pending", int'(bus.PENDING), 0);
        check("rst_dir", int'(bus.SCAN_DIR), 1);
        check("rst_door", int'(bus.DOOR_OPEN), 0);
        check("rst_tv", int'(bus.TARGET_VALID), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // move to floor 2, then a call for 6: latency and a full stop
        issue_batch(NF'(1 << 2));
        wait_done("t2_pre");
        plan_batch(NF'(1 << 6), int'(bus.CURRENT_FLOOR));
        @(negedge clk);
        bus.CALL_REQ = NF'(1 << 6);
        @(negedge clk);
        bus.CALL_REQ = '0;
        check("t2_pending_latency", int'(bus.PENDING[6]), 1);
        repeat (2) @(negedge clk);
        check("t2_requested", int'(bus.REQUESTED_FLOOR), 6);
        check("t2_tv", int'(bus.TARGET_VALID), 1);
        wait_done("t2");

        // reach floor 5 sweeping up, then calls {2,9}
        issue_batch(NF'(1 << 4));
        wait_done("t3_a");
        issue_batch(NF'(1 << 5));
        wait_done("t3_b");
        check("t3_dir_up", int'(bus.SCAN_DIR), 1);
        issue_batch(NF'((1 << 2) | (1 << 9)));
        wait_done("t3");

        // from 2 toward 9, call for 4 while passing 3
        plan_batch(NF'((1 << 4) | (1 << 9)), int'(bus.CURRENT_FLOOR));
        pulse_calls(NF'(1 << 9));
        n = 0;
        while (bus.CURRENT_FLOOR != FW'(3) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("t4_at_floor3", int'(bus.CURRENT_FLOOR), 3);
        bus.CALL_REQ = NF'(1 << 4);
        @(negedge clk);
        bus.CALL_REQ = '0;
        @(negedge clk);
        check("t4_pickup", int'(bus.REQUESTED_FLOOR), 4);
        wait_done("t4");

        // door alert held 5 cycles starting on the 4th open cycle
        plan_batch(NF'(1 << 12), int'(bus.CURRENT_FLOOR));
        void'(exp_dwell.pop_back());
        exp_dwell.push_back(3 + 5 + DW);
        pulse_calls(NF'(1 << 12));
        wait_door("t5a");
        repeat (3) @(negedge clk);
        bus.DOOR_ALERT = 1'b1;
        repeat (5) @(negedge clk);
        bus.DOOR_ALERT = 1'b0;
        wait_done("t5a");

        // call for the current floor on the 3rd open cycle
        plan_batch(NF'(1 << 10), int'(bus.CURRENT_FLOOR));
        void'(exp_dwell.pop_back());
        exp_dwell.push_back(3 + DW);
        pulse_calls(NF'(1 << 10));
        wait_door("t5b");
        repeat (2) @(negedge clk);
        bus.CALL_REQ = NF'(1 << 10);
        @(negedge clk);
        bus.CALL_REQ = '0;
        check("t5b_absorbed", int'(bus.PENDING[10]), 0);
        wait_done("t5b");

        // reset in the middle of a trip with {7,11} pending
        pulse_calls(NF'((1 << 7) | (1 << 11)));
        n = 0;
        while (!bus.TARGET_VALID && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("t6_in_travel", int'(bus.TARGET_VALID), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_pending", int'(bus.PENDING), 0);
        check("t6_tv", int'(bus.TARGET_VALID), 0);
        check("t6_req", int'(bus.REQUESTED_FLOOR), int'(bus.CURRENT_FLOOR));
        check("t6_dir", int'(bus.SCAN_DIR), 1);
        rst   = 1'b0;
        m_dir = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_stays_idle", int'(bus.TARGET_VALID), 0);
        check("t6_no_stop", int'(bus.DOOR_OPEN), 0);

        // random batches of calls from rest
        for (int b = 0; b < 12; b++) begin
            mask = NF'($urandom & $urandom);
            if (mask == '0) mask[$urandom_range(0, NF - 1)] = 1'b1;
            issue_batch(mask);
            wait_done("rand");
        end

        check("left_stops", exp_stop.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
